se_pair_sequencer: RTL and testbench

Sequencer and timing monitor for a self-composed pair of SE units. Accepts one public instruction (inst, op1, op2) with two secret conditions, issues it to SE unit One and SE unit Two with independent per-unit handshakes, and captures both results. Records the issue-accept and result-arrival cycle of each unit. Reports the two results together with a timing-leak verdict, skew and timeout status. Sits between the test stimulus source and the two SE instances in the self-composition tester.

---
 rtl/se_pair_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_se_pair_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/se_pair_sequencer.sv
// Issues one public request to two self-composed SE units, captures both results and
// reports them with a timing-leak verdict built from per-unit accept/arrival cycles.
module se_pair_sequencer #(
  parameter int W       = 128,
  parameter int INST_W  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INST_W-1:0] io_in_inst,
  input  logic [W-1:0]      io_in_op1,
  input  logic [W-1:0]      io_in_op2,
  input  logic [W-1:0]      io_in_condOne,
  input  logic [W-1:0]      io_in_condTwo,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  output logic [INST_W-1:0] se_in_inst,
  output logic [W-1:0]      se_in_op1,
  output logic [W-1:0]      se_in_op2,
  output logic [W-1:0]      se_in_condOne,
  output logic [W-1:0]      se_in_condTwo,
  output logic              se_in_validOne,
  output logic              se_in_validTwo,
  input  logic              se_in_readyOne,
  input  logic              se_in_readyTwo,
  input  logic [W-1:0]      se_out_resultOne,
  input  logic [W-1:0]      se_out_resultTwo,
  input  logic              se_out_validOne,
  input  logic              se_out_validTwo,
  output logic              se_out_readyOne,
  output logic              se_out_readyTwo,
  output logic [W-1:0]      io_out_resultOne,
  output logic [W-1:0]      io_out_resultTwo,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [CNT_W-1:0]  io_out_skew,
  output logic              timingLeak,
  output logic              timeout,
  output logic              timingLeakDone,
  output logic              leakSeen
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] acc_one, acc_two, arr_one, arr_two;
  logic             captured_one, captured_two;
  logic [W-1:0]     res_one, res_two;

  logic issue_one, issue_two, cap_one, cap_two;
  logic cap_now_one, cap_now_two, both_done, at_limit;

  // The per-unit valid/ready outputs are registers that are only ever high in RUN,
  // so the handshakes below need no extra state qualification.
  assign issue_one   = se_in_validOne & se_in_readyOne;
  assign issue_two   = se_in_validTwo & se_in_readyTwo;
  assign cap_one     = se_out_readyOne & se_out_validOne;
  assign cap_two     = se_out_readyTwo & se_out_validTwo;
  assign cap_now_one = captured_one | cap_one;
  assign cap_now_two = captured_two | cap_two;
  assign both_done   = captured_one & captured_two;
  assign at_limit    = (cnt == CNT_W'(TIMEOUT - 1));

  assign timingLeakDone = io_out_valid & io_out_ready;

  // NOTE: every register here is assigned with <= so all updates in a cycle see the
  // pre-edge values; later assignments in the same branch deliberately override earlier ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      acc_one          <= '0;
      acc_two          <= '0;
      arr_one          <= '0;
      arr_two          <= '0;
      captured_one     <= 1'b0;
      captured_two     <= 1'b0;
      res_one          <= '0;
      res_two          <= '0;
      io_in_ready      <= 1'b1;
      se_in_inst       <= '0;
      se_in_op1        <= '0;
      se_in_op2        <= '0;
      se_in_condOne    <= '0;
      se_in_condTwo    <= '0;
      se_in_validOne   <= 1'b0;
      se_in_validTwo   <= 1'b0;
      se_out_readyOne  <= 1'b0;
      se_out_readyTwo  <= 1'b0;
      io_out_resultOne <= '0;
      io_out_resultTwo <= '0;
      io_out_valid     <= 1'b0;
      io_out_skew      <= '0;
      timingLeak       <= 1'b0;
      timeout          <= 1'b0;
      leakSeen         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            se_in_inst     <= io_in_inst;
            se_in_op1      <= io_in_op1;
            se_in_op2      <= io_in_op2;
            se_in_condOne  <= io_in_condOne;
            se_in_condTwo  <= io_in_condTwo;
            captured_one   <= 1'b0;
            captured_two   <= 1'b0;
            cnt            <= '0;
            se_in_validOne <= 1'b1;
            se_in_validTwo <= 1'b1;
            io_in_ready    <= 1'b0;
            state          <= RUN;
          end
        end

        RUN: begin
          if (issue_one) begin
            se_in_validOne  <= 1'b0;
            se_out_readyOne <= 1'b1;
            acc_one         <= cnt;
          end
          if (issue_two) begin
            se_in_validTwo  <= 1'b0;
            se_out_readyTwo <= 1'b1;
            acc_two         <= cnt;
          end
          if (cap_one) begin
            se_out_readyOne <= 1'b0;
            res_one         <= se_out_resultOne;
            captured_one    <= 1'b1;
            arr_one         <= cnt;
          end
          if (cap_two) begin
            se_out_readyTwo <= 1'b0;
            res_two         <= se_out_resultTwo;
            captured_two    <= 1'b1;
            arr_two         <= cnt;
          end
          // cnt never reaches 2^CNT_W here since RUN ends by TIMEOUT-1.
          cnt <= cnt + 1'b1;

          if (both_done || at_limit) begin
            se_in_validOne  <= 1'b0;
            se_in_validTwo  <= 1'b0;
            se_out_readyOne <= 1'b0;
            se_out_readyTwo <= 1'b0;
            io_out_valid    <= 1'b1;
            state           <= REPORT;
          end

          if (both_done) begin
            io_out_resultOne <= res_one;
            io_out_resultTwo <= res_two;
            io_out_skew      <= arr_two - arr_one;
            timingLeak       <= (acc_one != acc_two) | (arr_one != arr_two);
            timeout          <= 1'b0;
          end else if (at_limit) begin
            // Forced report: a result landing in this very cycle still counts as captured.
            io_out_resultOne <= cap_one ? se_out_resultOne : (captured_one ? res_one : '0);
            io_out_resultTwo <= cap_two ? se_out_resultTwo : (captured_two ? res_two : '0);
            io_out_skew      <= '0;
            timingLeak       <= cap_now_one != cap_now_two;
            timeout          <= 1'b1;
          end
        end

        REPORT: begin
          if (io_out_ready) begin
            io_out_valid <= 1'b0;
            leakSeen     <= leakSeen | timingLeak;
            io_in_ready  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_se_pair_sequencer.sv
// Randomised and directed bench for se_pair_sequencer; expectations come from an
// arithmetic timeline model of each transaction (accept cycle, arrival cycle, report length).
module tb_se_pair_sequencer;

  localparam int W      = 128;
  localparam int INST_W = 8;
  localparam int CNT_W  = 16;
  localparam int T      = 16;
  localparam int NEVER  = 1000;

  logic              clock = 1'b0;
  logic              reset;
  logic [INST_W-1:0] io_in_inst;
  logic [W-1:0]      io_in_op1, io_in_op2, io_in_condOne, io_in_condTwo;
  logic              io_in_valid, io_in_ready;
  logic [INST_W-1:0] se_in_inst;
  logic [W-1:0]      se_in_op1, se_in_op2, se_in_condOne, se_in_condTwo;
  logic              se_in_validOne, se_in_validTwo, se_in_readyOne, se_in_readyTwo;
  logic [W-1:0]      se_out_resultOne, se_out_resultTwo;
  logic              se_out_validOne, se_out_validTwo, se_out_readyOne, se_out_readyTwo;
  logic [W-1:0]      io_out_resultOne, io_out_resultTwo;
  logic              io_out_valid, io_out_ready;
  logic [CNT_W-1:0]  io_out_skew;
  logic              timingLeak, timeout, timingLeakDone, leakSeen;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_leak_seen = 1'b0;

  always #5 clock = ~clock;

  se_pair_sequencer #(.W(W), .INST_W(INST_W), .CNT_W(CNT_W), .TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .io_in_inst(io_in_inst), .io_in_op1(io_in_op1), .io_in_op2(io_in_op2),
    .io_in_condOne(io_in_condOne), .io_in_condTwo(io_in_condTwo),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .se_in_inst(se_in_inst), .se_in_op1(se_in_op1), .se_in_op2(se_in_op2),
    .se_in_condOne(se_in_condOne), .se_in_condTwo(se_in_condTwo),
    .se_in_validOne(se_in_validOne), .se_in_validTwo(se_in_validTwo),
    .se_in_readyOne(se_in_readyOne), .se_in_readyTwo(se_in_readyTwo),
    .se_out_resultOne(se_out_resultOne), .se_out_resultTwo(se_out_resultTwo),
    .se_out_validOne(se_out_validOne), .se_out_validTwo(se_out_validTwo),
    .se_out_readyOne(se_out_readyOne), .se_out_readyTwo(se_out_readyTwo),
    .io_out_resultOne(io_out_resultOne), .io_out_resultTwo(io_out_resultTwo),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_skew(io_out_skew), .timingLeak(timingLeak), .timeout(timeout),
    .timingLeakDone(timingLeakDone), .leakSeen(leakSeen)
  );

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    io_in_valid     = 1'b0;
    io_out_ready    = 1'b0;
    se_in_readyOne  = 1'b0;
    se_in_readyTwo  = 1'b0;
    se_out_validOne = 1'b0;
    se_out_validTwo = 1'b0;
  endtask

  // Unit X accepts at cnt=iaX and returns its result rdX cycles later (NEVER = not at all).
  // Entered and left just after a negedge in an IDLE cycle.
  task automatic run_txn(input int ia1, input int rd1, input int ia2, input int rd2,
                         input int hold, output logic got_leak, output logic [CNT_W-1:0] got_skew,
                         output logic got_to, output logic [W-1:0] got_res2, output int lat);
    int arr1, arr2, amax, run_len;
    bit normal, cap1, cap2, e_leak;
    logic [CNT_W-1:0]  e_skew;
    logic [W-1:0]      d1, d2, e_res1, e_res2, op1, op2, c1, c2;
    logic [INST_W-1:0] inst;

    arr1 = ia1 + rd1;
    arr2 = ia2 + rd2;
    amax = (arr1 > arr2) ? arr1 : arr2;
    normal = (amax + 2 <= T);
    run_len = normal ? amax + 2 : T;
    cap1 = arr1 <= T - 1;
    cap2 = arr2 <= T - 1;
    d1 = rnd_w();
    d2 = rnd_w();
    if (normal) begin
      e_leak = (ia1 != ia2) || (arr1 != arr2);
      e_skew = CNT_W'(arr2 - arr1);
      e_res1 = d1;
      e_res2 = d2;
    end else begin
      e_leak = cap1 != cap2;
      e_skew = '0;
      e_res1 = cap1 ? d1 : '0;
      e_res2 = cap2 ? d2 : '0;
    end
    lat = run_len;

    inst = INST_W'($urandom());
    op1 = rnd_w(); op2 = rnd_w(); c1 = rnd_w(); c2 = rnd_w();
    io_in_inst = inst; io_in_op1 = op1; io_in_op2 = op2;
    io_in_condOne = c1; io_in_condTwo = c2;
    idle_inputs();
    io_in_valid = 1'b1;
    @(posedge clock);

    for (int c = 0; c < run_len; c++) begin
      @(negedge clock);
      check("run_in_ready", io_in_ready, 0);
      check("run_out_valid", io_out_valid, 0);
      check("run_vld1", se_in_validOne, (c <= ia1));
      check("run_vld2", se_in_validTwo, (c <= ia2));
      check("run_rdy1", se_out_readyOne, (c > ia1 && c <= arr1));
      check("run_rdy2", se_out_readyTwo, (c > ia2 && c <= arr2));
      check("run_inst", se_in_inst, inst);
      check("run_op1", se_in_op1, op1);
      check("run_op2", se_in_op2, op2);
      check("run_cond1", se_in_condOne, c1);
      check("run_cond2", se_in_condTwo, c2);
      io_in_valid      = 1'($urandom_range(0, 1));
      io_in_inst       = ~inst;
      se_in_readyOne   = (c >= ia1);
      se_in_readyTwo   = (c >= ia2);
      se_out_validOne  = (c >= arr1);
      se_out_validTwo  = (c >= arr2);
      se_out_resultOne = (c == arr1) ? d1 : rnd_w();
      se_out_resultTwo = (c == arr2) ? d2 : rnd_w();
    end

    for (int k = 0; k <= hold; k++) begin
      @(negedge clock);
      check("rep_valid", io_out_valid, 1);
      check("rep_in_ready", io_in_ready, 0);
      check("rep_res1", io_out_resultOne, e_res1);
      check("rep_res2", io_out_resultTwo, e_res2);
      check("rep_skew", io_out_skew, e_skew);
      check("rep_leak", timingLeak, e_leak);
      check("rep_timeout", timeout, !normal);
      check("rep_se_quiet", {se_in_validOne, se_in_validTwo, se_out_readyOne, se_out_readyTwo}, 0);
      check("rep_inst_held", se_in_inst, inst);
      check("rep_seen_before", leakSeen, exp_leak_seen);
      if (k == 0) begin
        got_leak = timingLeak;
        got_skew = io_out_skew;
        got_to   = timeout;
        got_res2 = io_out_resultTwo;
      end
      io_out_ready = (k == hold);
      io_in_valid  = 1'b1;
      io_in_inst   = ~inst;
      #1;
      check("rep_done", timingLeakDone, (k == hold));
    end
    exp_leak_seen = exp_leak_seen | e_leak;

    @(negedge clock);
    idle_inputs();
    check("idle_in_ready", io_in_ready, 1);
    check("idle_out_valid", io_out_valid, 0);
    check("idle_done", timingLeakDone, 0);
    check("idle_seen", leakSeen, exp_leak_seen);
    check("idle_se_valid", {se_in_validOne, se_in_validTwo}, 0);
  endtask

  logic             g_leak, g_to;
  logic [CNT_W-1:0] g_skew;
  logic [W-1:0]     g_res2;
  int               g_lat;

  initial begin
    reset = 1'b1;
    io_in_inst = '0; io_in_op1 = '0; io_in_op2 = '0;
    io_in_condOne = '0; io_in_condTwo = '0;
    se_out_resultOne = '0; se_out_resultTwo = '0;
    idle_inputs();
    repeat (2) @(negedge clock);
    check("rst_in_ready", io_in_ready, 1);
    check("rst_se_vr", {se_in_validOne, se_in_validTwo, se_out_readyOne, se_out_readyTwo}, 0);
    check("rst_flags", {io_out_valid, timingLeak, timeout, timingLeakDone, leakSeen}, 0);
    check("rst_res1", io_out_resultOne, 0);
    check("rst_res2", io_out_resultTwo, 0);
    check("rst_skew", io_out_skew, 0);
    check("rst_req", se_in_op1, 0);
    reset = 1'b0;

    // Both units at cnt=0, results at cnt=3.
    run_txn(0, 3, 0, 3, 0, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin1_lat", g_lat, 5);
    check("pin1_leak", g_leak, 0);
    check("pin1_skew", g_skew, 0);
    check("pin1_to", g_to, 0);

    // Two arrives 2 cycles after One.
    run_txn(0, 3, 0, 5, 1, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin2_leak", g_leak, 1);
    check("pin2_skew", g_skew, 2);
    check("pin2_seen", leakSeen, 1);

    // Two accepted one cycle late.
    run_txn(0, 3, 1, 3, 0, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin3_leak", g_leak, 1);
    check("pin3_skew", g_skew, 1);

    // Two never returns a result.
    run_txn(0, 3, 0, NEVER, 0, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin4_lat", g_lat, 16);
    check("pin4_to", g_to, 1);
    check("pin4_leak", g_leak, 1);
    check("pin4_res2", g_res2, 0);
    check("pin4_skew", g_skew, 0);

    // Report held for 5 cycles.
    run_txn(1, 2, 1, 2, 5, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin5_leak", g_leak, 0);

    // Last capture at cnt=14 completes normally; at cnt=15 it lands in the timeout cycle.
    run_txn(0, 14, 0, 3, 0, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin6_to", g_to, 0);
    check("pin6_skew", g_skew, 16'hFFF5);
    run_txn(0, 15, 0, 15, 0, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin7_to", g_to, 1);
    check("pin7_leak", g_leak, 0);

    // Unit One never accepts.
    run_txn(NEVER, 1, 2, 2, 0, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin8_leak", g_leak, 1);

    // Reset in the middle of RUN.
    io_in_inst = 8'h5A; io_in_op1 = rnd_w();
    io_in_valid = 1'b1;
    @(posedge clock);
    repeat (3) @(negedge clock);
    io_in_valid = 1'b0;
    check("mid_run_valid", se_in_validOne, 1);
    reset = 1'b1;
    #1;
    exp_leak_seen = 1'b0;
    check("mrst_in_ready", io_in_ready, 1);
    check("mrst_se_vr", {se_in_validOne, se_in_validTwo, se_out_readyOne, se_out_readyTwo}, 0);
    check("mrst_flags", {io_out_valid, timingLeakDone, leakSeen}, 0);
    check("mrst_req", se_in_inst, 0);
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();

    // Fastest possible transaction after reset.
    run_txn(0, 1, 0, 1, 0, g_leak, g_skew, g_to, g_res2, g_lat);
    check("pin9_lat", g_lat, 3);
    check("pin9_leak", g_leak, 0);

    for (int i = 0; i < 60; i++) begin
      int ia1, rd1, ia2, rd2;
      ia1 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 7));
      ia2 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 7));
      rd1 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 9));
      rd2 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 9));
      run_txn(ia1, rd1, ia2, rd2, int'($urandom_range(0, 3)), g_leak, g_skew, g_to, g_res2, g_lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
